// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with valid/ready handshakes on both sides.
// Define ALU_SEQ_MUL_EN to compile in the iterative shift-add multiplier (opcode 1101).
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH-1:0]   r_out;
  logic               r_valid, r_c, r_z, r_n, r_v;
  logic [WIDTH:0]     w_sum, w_dif;
  logic [WIDTH-1:0]   w_res, w_wd;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_c, w_v, w_nul, w_free, w_acc, w_wr, w_msel, w_wc, w_wv, w_wq;
  assign w_sum  = {1'b0, x} + {1'b0, y};
  assign w_dif  = {1'b0, x} - {1'b0, y};
  assign w_free = !r_valid || out_ready;
  assign w_acc  = in_valid && in_ready;
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (ctrl)
      4'h0: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (x[WIDTH-1] == y[WIDTH-1]) && (w_sum[WIDTH-1] != x[WIDTH-1]);
      end
      4'h1: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (x[WIDTH-1] != y[WIDTH-1]) && (w_dif[WIDTH-1] != x[WIDTH-1]);
      end
      4'h2: w_res = x & y;
      4'h3: w_res = x | y;
      4'h4: w_res = ~x;
      4'h5: w_res = x ^ y;
      4'h6: w_res = ~(x | y);
      4'h7: w_res = y << x[SHW-1:0];
      4'h8: w_res = y >> x[SHW-1:0];
      4'h9: w_res = {x[WIDTH-1], x[WIDTH-1:1]};
      4'hA: w_res = {x[WIDTH-2:0], x[WIDTH-1]};
      4'hB: w_res = {x[0], x[WIDTH-1:1]};
      4'hC: w_res = {{(WIDTH-1){1'b0}}, x == y};
      default: w_res = '0;
    endcase
  end
  // Reserved opcodes report result 0 with every flag clear, including zero.
  assign w_wd = w_msel ? w_prod[WIDTH-1:0] : w_res;
  assign w_wc = w_msel ? |w_prod[2*WIDTH-1:WIDTH] : w_c;
  assign w_wv = w_msel ? 1'b0 : w_v;
  assign w_wq = w_msel || !w_nul;
`ifdef ALU_SEQ_MUL_EN
  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_FULL = CW'(WIDTH);
  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t             r_st, w_nst;
  logic [2*WIDTH-1:0] r_acc, w_step;
  logic [WIDTH-1:0]   r_mx;
  logic [CW-1:0]      r_cnt;
  logic               w_mstart, w_mdone;
  // One shift-add iteration: the low half holds the unconsumed multiplier bits.
  function automatic logic [2*WIDTH-1:0] f_step(input logic [2*WIDTH-1:0] a, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, a[2*WIDTH-1:WIDTH]} + (a[0] ? {1'b0, m} : '0);
    return {s, a[WIDTH-1:1]};
  endfunction
  assign w_mstart = w_acc && ctrl == 4'hD;
  assign w_step   = f_step(r_acc, r_mx);
  assign w_prod   = (r_cnt == C_FULL) ? r_acc : w_step;
  assign w_mdone  = r_st == S_MUL && r_cnt >= C_LAST && w_free;
  assign w_msel   = r_st == S_MUL;
  assign w_wr     = (w_acc && !w_mstart) || w_mdone;
  assign w_nul    = ctrl >= 4'hE;
  assign in_ready = !rst && r_st == S_IDLE && w_free;
  always_comb begin
    w_nst = r_st;
    w_nst = (r_st == S_IDLE) ? (w_mstart ? S_MUL : S_IDLE) : (w_mdone ? S_IDLE : S_MUL);
  end
  // The first iteration runs on the accept edge and the last one feeds the output directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st  <= S_IDLE;
      r_acc <= '0;
      r_mx  <= '0;
      r_cnt <= '0;
    end else begin
      r_st <= w_nst;
      if (w_mstart) begin
        r_mx  <= x;
        r_acc <= f_step({{WIDTH{1'b0}}, y}, x);
        r_cnt <= CW'(1);
      end else if (r_st == S_MUL) begin
        r_acc <= w_prod;
        r_cnt <= (r_cnt == C_FULL) ? C_FULL : r_cnt + 1'b1;
      end
    end
  end
`else
  assign w_prod   = '0;
  assign w_msel   = 1'b0;
  assign w_wr     = w_acc;
  assign w_nul    = ctrl >= 4'hD;
  assign in_ready = !rst && w_free;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      if (w_wr) begin
        r_out <= w_wd;
        r_c   <= w_wc;
        r_z   <= w_wq && w_wd == '0;
        r_n   <= w_wq && w_wd[WIDTH-1];
        r_v   <= w_wv;
      end
      r_valid <= w_wr || (r_valid && !out_ready);
    end
  end
  assign out       = r_out;
  assign out_valid = r_valid;
  assign carry     = r_c;
  assign zero      = r_z;
  assign neg       = r_n;
  assign ovf       = r_v;
endmodule
